// File: rtl/mem_bus_arbiter.sv
// Shared memory/IO bus arbiter: grants one master at a time, routes its
// byte transfers to RAM or the IO window and returns read data one cycle later.
module mem_bus_arbiter #(
    parameter int unsigned NUM_MASTERS    = 2,
    parameter int unsigned RAM_ADDR_WIDTH = 17,
    parameter int unsigned ARB_MODE       = 0,
    parameter int unsigned MAX_BURST      = 4
) (
    input  logic                        clk_in,
    input  logic                        rst_n_in,
    input  logic                        rdy_in,
    input  logic [NUM_MASTERS-1:0]      m_req_in,
    input  logic [NUM_MASTERS-1:0]      m_lock_in,
    input  logic [NUM_MASTERS-1:0]      m_wr_in,
    input  logic [32*NUM_MASTERS-1:0]   m_a_in,
    input  logic [8*NUM_MASTERS-1:0]    m_dout_in,
    output logic [NUM_MASTERS-1:0]      m_gnt_out,
    output logic [NUM_MASTERS-1:0]      m_rvalid_out,
    output logic [7:0]                  m_din_out,
    output logic                        ram_en_out,
    output logic                        ram_r_nw_out,
    output logic [RAM_ADDR_WIDTH-1:0]   ram_a_out,
    output logic [7:0]                  ram_d_out,
    input  logic [7:0]                  ram_d_in,
    output logic                        io_en_out,
    output logic [2:0]                  io_sel_out,
    output logic                        io_wr_out,
    output logic [7:0]                  io_d_out,
    input  logic [7:0]                  io_d_in
);

    localparam int unsigned OW = (NUM_MASTERS > 2) ? 2 : 1;
    localparam int unsigned CW = 4;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [OW-1:0]          owner_q, owner_d;
    logic [OW-1:0]          ptr_q, ptr_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [NUM_MASTERS-1:0] rvalid_q, rvalid_d;
    logic                   rio_q, rio_d;

    logic [31:0]   own_a;
    logic [7:0]    own_d;
    logic          own_req, own_lock, own_wr, own_io;
    logic          xfer;
    logic [OW-1:0] win, cand;
    logic          found;
    logic          unused_a;

    // Select the current owner's request, lock, address and data
    always_comb begin
        own_a    = '0;
        own_d    = '0;
        own_req  = 1'b0;
        own_lock = 1'b0;
        own_wr   = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (owner_q == OW'(i)) begin
                own_a    = m_a_in[32*i +: 32];
                own_d    = m_dout_in[8*i +: 8];
                own_req  = m_req_in[i];
                own_lock = m_lock_in[i];
                own_wr   = m_wr_in[i];
            end
        end
    end

    assign own_io   = (own_a[RAM_ADDR_WIDTH -: 2] == 2'b11);
    assign xfer     = (state_q == OWN) && rdy_in && own_req;
    assign unused_a = ^own_a[31:RAM_ADDR_WIDTH+1];

    // Winner search: from the rotating pointer (round-robin) or from index 0
    always_comb begin
        win   = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (ARB_MODE == 1) begin
                cand = OW'(i);
            end else begin
                cand = OW'((32'(ptr_q) + i) % NUM_MASTERS);
            end
            if (!found && m_req_in[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
    end

    // Grant is a decode of the registered state and owner
    always_comb begin
        m_gnt_out = '0;
        if (state_q == OWN) begin
            m_gnt_out[owner_q] = 1'b1;
        end
    end

    // Next-state logic: arbitration, burst counting and release
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        rvalid_d = '0;
        rio_d    = rio_q;
        if (xfer && !own_wr) begin
            rvalid_d = m_gnt_out;
            rio_d    = own_io;
        end
        case (state_q)
            IDLE: begin
                if (rdy_in && (|m_req_in)) begin
                    state_d = OWN;
                    owner_d = win;
                    cnt_d   = '0;
                end
            end
            OWN: begin
                if (rdy_in) begin
                    if (own_req) begin
                        cnt_d = cnt_q + CW'(1);
                    end
                    if (!own_req || !own_lock || ((cnt_q + CW'(1)) == CW'(MAX_BURST))) begin
                        state_d = IDLE;
                        if (ARB_MODE == 0) begin
                            ptr_d = (owner_q == OW'(NUM_MASTERS-1)) ? '0 : owner_q + OW'(1);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, owner, pointer, counter and read-return registers
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            ptr_q    <= '0;
            cnt_q    <= '0;
            rvalid_q <= '0;
            rio_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
            rio_q    <= rio_d;
        end
    end

    assign ram_en_out   = xfer && !own_io;
    assign ram_r_nw_out = ~own_wr;
    assign ram_a_out    = own_a[RAM_ADDR_WIDTH-1:0];
    assign ram_d_out    = own_d;
    assign io_en_out    = xfer && own_io;
    assign io_sel_out   = own_a[2:0];
    assign io_wr_out    = own_wr;
    assign io_d_out     = own_d;
    assign m_rvalid_out = rvalid_q;
    assign m_din_out    = (|rvalid_q) ? (rio_q ? io_d_in : ram_d_in) : 8'h00;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: a round-robin and a fixed-priority instance share
// stimulus; a transaction-level model predicts every output each cycle.
module tb_mem_bus_arbiter;

    localparam int NM = 3;
    localparam int AW = 17;
    localparam int MB = 4;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic             rst_n, rdy;
    logic [NM-1:0]    req, lock, wr;
    logic [32*NM-1:0] ma;
    logic [8*NM-1:0]  md;
    logic [7:0]       ram_di, io_di;

    logic [NM-1:0] gnt [2];
    logic [NM-1:0] rv [2];
    logic [7:0]    din [2];
    logic [7:0]    ram_d [2];
    logic [7:0]    io_d [2];
    logic          ram_en [2];
    logic          ram_rnw [2];
    logic          io_en [2];
    logic          io_wr [2];
    logic [AW-1:0] ram_a [2];
    logic [2:0]    io_sel [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_bus_arbiter #(
            .NUM_MASTERS(NM), .RAM_ADDR_WIDTH(AW), .ARB_MODE(g), .MAX_BURST(MB)
        ) u_dut (
            .clk_in(clk_in), .rst_n_in(rst_n), .rdy_in(rdy),
            .m_req_in(req), .m_lock_in(lock), .m_wr_in(wr),
            .m_a_in(ma), .m_dout_in(md),
            .m_gnt_out(gnt[g]), .m_rvalid_out(rv[g]), .m_din_out(din[g]),
            .ram_en_out(ram_en[g]), .ram_r_nw_out(ram_rnw[g]), .ram_a_out(ram_a[g]),
            .ram_d_out(ram_d[g]), .ram_d_in(ram_di),
            .io_en_out(io_en[g]), .io_sel_out(io_sel[g]), .io_wr_out(io_wr[g]),
            .io_d_out(io_d[g]), .io_d_in(io_di)
        );
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: k=0 round-robin, k=1 fixed priority
    bit mbusy [2];
    int mown [2];
    int mcnt [2];
    int mptr [2];
    int mrv [2];
    bit mrio [2];

    function automatic logic [31:0] a_of(input int i);
        return ma[32*i +: 32];
    endfunction

    function automatic bit is_io(input int i);
        return ((a_of(i) >> (AW-1)) & 32'd3) == 32'd3;
    endfunction

    function automatic int pick(input int k);
        for (int i = 0; i < NM; i++) begin
            int j;
            j = (k == 0) ? (mptr[k] + i) % NM : i;
            if (req[j]) return j;
        end
        return 0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mbusy[k] = 0; mown[k] = 0; mcnt[k] = 0; mptr[k] = 0; mrv[k] = 0; mrio[k] = 0;
        end
    endtask

    task automatic model_step(input int k);
        int o;
        bit x;
        o = mown[k];
        x = mbusy[k] && rdy && req[o];
        mrv[k]  = (x && !wr[o]) ? (1 << o) : 0;
        mrio[k] = is_io(o);
        if (!mbusy[k]) begin
            if (rdy && req != '0) begin
                mown[k] = pick(k); mbusy[k] = 1; mcnt[k] = 0;
            end
        end else if (rdy) begin
            if (x) mcnt[k]++;
            if (!x || !lock[o] || mcnt[k] == MB) begin
                mbusy[k] = 0;
                mptr[k]  = (o + 1) % NM;
            end
        end
    endtask

    task automatic compare(input int k);
        int o;
        bit x, io;
        logic [31:0] a;
        o  = mown[k];
        x  = mbusy[k] && rdy && req[o];
        io = is_io(o);
        a  = a_of(o);
        chk($sformatf("gnt%0d", k), 32'(gnt[k]), mbusy[k] ? 32'(1 << o) : 32'd0);
        chk($sformatf("ram_en%0d", k), 32'(ram_en[k]), 32'(x && !io));
        chk($sformatf("io_en%0d", k), 32'(io_en[k]), 32'(x && io));
        if (x && !io) begin
            chk($sformatf("ram_a%0d", k), 32'(ram_a[k]), a & ((32'd1 << AW) - 1));
            chk($sformatf("ram_rnw%0d", k), 32'(ram_rnw[k]), 32'(!wr[o]));
            if (wr[o]) chk($sformatf("ram_d%0d", k), 32'(ram_d[k]), 32'(md[8*o +: 8]));
        end
        if (x && io) begin
            chk($sformatf("io_sel%0d", k), 32'(io_sel[k]), a & 32'd7);
            chk($sformatf("io_wr%0d", k), 32'(io_wr[k]), 32'(wr[o]));
            if (wr[o]) chk($sformatf("io_d%0d", k), 32'(io_d[k]), 32'(md[8*o +: 8]));
        end
        chk($sformatf("rvalid%0d", k), 32'(rv[k]), 32'(mrv[k]));
        chk($sformatf("din%0d", k), 32'(din[k]),
            (mrv[k] != 0) ? 32'(mrio[k] ? io_di : ram_di) : 32'd0);
    endtask

    // Compare every cycle at the falling edge, then advance the model
    initial forever begin
        @(negedge clk_in);
        if (!rst_n) model_reset();
        for (int k = 0; k < 2; k++) compare(k);
        if (rst_n) for (int k = 0; k < 2; k++) model_step(k);
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic mid();
        @(negedge clk_in);
        #1;
    endtask

    int e0 [6] = '{0, 2, 0, 1, 0, 2};
    int e1 [6] = '{0, 1, 0, 1, 0, 1};
    int xf, run, nr;
    int runs [2];
    logic [31:0] r;

    initial begin
        rst_n = 0; rdy = 1; req = '0; lock = '0; wr = '0; ma = '0; md = '0;
        ram_di = '0; io_di = '0;
        model_reset();
        tick();
        mid();
        chk("rst_gnt", 32'(gnt[0]), 0);
        chk("rst_rv", 32'(rv[0]), 0);
        chk("rst_din", 32'(din[0]), 0);
        chk("rst_en", 32'({ram_en[0], io_en[0]}), 0);
        tick();

        // Single read from master 0
        rst_n = 1; req = 3'b001; ma[31:0] = 32'h10; ram_di = 8'h5A;
        mid();
        chk("sr_idle_gnt", 32'(gnt[0]), 0);
        tick();
        mid();
        chk("sr_gnt_rr", 32'(gnt[0]), 1);
        chk("sr_gnt_fp", 32'(gnt[1]), 1);
        chk("sr_ram_en", 32'(ram_en[0]), 1);
        chk("sr_ram_a", 32'(ram_a[0]), 32'h10);
        chk("sr_rnw", 32'(ram_rnw[0]), 1);
        tick();
        req = '0;
        mid();
        chk("sr_rvalid", 32'(rv[0]), 1);
        chk("sr_din", 32'(din[0]), 32'h5A);
        chk("sr_release", 32'(gnt[0]), 0);
        tick();
        mid();
        chk("sr_rv_clear", 32'(rv[0]), 0);
        tick();

        // Masters 0 and 1 requesting continuously, no lock
        req = 3'b011;
        for (int c = 0; c < 6; c++) begin
            mid();
            chk($sformatf("rr_seq%0d", c), 32'(gnt[0]), 32'(e0[c]));
            chk($sformatf("fp_seq%0d", c), 32'(gnt[1]), 32'(e1[c]));
            tick();
        end
        req = '0;
        tick(); tick();

        // Locked burst of 6 reads from master 1
        req = 3'b010; lock = 3'b010; ma[63:32] = 32'h100;
        xf = 0; run = 0; nr = 0;
        for (int c = 0; c < 40 && nr < 2; c++) begin
            mid();
            if (gnt[0] == 3'b010 && ram_en[0]) begin
                xf++; run++;
            end else if (gnt[0] == 3'b000 && run > 0) begin
                runs[nr] = run; nr++; run = 0;
            end
            tick();
            if (xf >= 6) req = '0;
        end
        chk("burst_grants", 32'(nr), 2);
        if (nr == 2) begin
            chk("burst_first", 32'(runs[0]), 4);
            chk("burst_second", 32'(runs[1]), 2);
        end
        req = '0; lock = '0;
        tick();

        // IO write with a 3-cycle pause
        ma[95:64] = 32'h0003_0004; md[23:16] = 8'hC3; wr = 3'b100; req = 3'b100;
        mid();
        chk("io_idle", 32'(gnt[0]), 0);
        tick();
        rdy = 0;
        for (int c = 0; c < 3; c++) begin
            mid();
            chk($sformatf("pause_gnt%0d", c), 32'(gnt[0]), 4);
            chk($sformatf("pause_en%0d", c), 32'({ram_en[0], io_en[0]}), 0);
            tick();
        end
        rdy = 1;
        mid();
        chk("io_en", 32'(io_en[0]), 1);
        chk("io_sel", 32'(io_sel[0]), 4);
        chk("io_wr", 32'(io_wr[0]), 1);
        chk("io_d", 32'(io_d[0]), 32'hC3);
        chk("io_ram_en", 32'(ram_en[0]), 0);
        tick();
        req = '0; wr = '0;
        mid();
        chk("io_release", 32'(gnt[0]), 0);
        tick();

        // Reset in the cycle after a read is issued
        req = 3'b001; ma[31:0] = 32'h20;
        mid();
        tick();
        mid();
        chk("rr_issue", 32'(ram_en[0]), 1);
        tick();
        rst_n = 0; req = '0;
        mid();
        chk("rst_rv0", 32'(rv[0]), 0);
        chk("rst_rv1", 32'(rv[1]), 0);
        chk("rst_gnt0", 32'(gnt[0]), 0);
        chk("rst_din0", 32'(din[0]), 0);
        chk("rst_en0", 32'({ram_en[0], io_en[0]}), 0);
        tick(); tick();
        rst_n = 1;

        // Randomised traffic
        for (int c = 0; c < 2000; c++) begin
            rdy    = ($urandom_range(0, 7) != 0);
            req    = NM'($urandom);
            lock   = NM'($urandom);
            wr     = NM'($urandom);
            md     = (8*NM)'($urandom);
            ram_di = 8'($urandom);
            io_di  = 8'($urandom);
            for (int i = 0; i < NM; i++) begin
                r = $urandom;
                if ($urandom_range(0, 2) == 0) r[17:16] = 2'b11;
                ma[32*i +: 32] = r;
            end
            rst_n = (c % 700 != 699);
            tick();
        end
        rst_n = 1; req = '0;
        tick(); tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
